e_mdu: RTL and testbench

E-stage multiply/divide unit of the five-stage MIPS pipeline. It accepts mult/multu/div/divu, models their multi-cycle latency with a busy counter, and owns the HI/LO registers. It serves mfhi/mflo as an E-stage result, so the value reaches the E-stage write-data mux and from there the D-stage forwarding path. It also raises the D-stage stall request for any MDU instruction that arrives while an operation is pending.

---
 rtl/mdu_defs.sv | 25 ++
 rtl/mdu_arith.sv | 69 ++++++
 rtl/e_mdu.sv | 109 ++++++++++
 tb/tb_e_mdu.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mdu_defs.sv
// Shared definitions for the E-stage multiply/divide unit: op codes, FSM states and
// default latencies.
package mdu_defs;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath for mult/multu/div/divu, including the MIPS divide-by-zero
// and signed-overflow results.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic [63:0]        prod_u;
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic               div_zero, div_ovf;
  logic [31:0]        b_safe;
  logic signed [31:0] a_s, b_s, quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;

  assign prod_u = {32'b0, a} * {32'b0, b};
  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;

  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Keep the divider inputs well-defined on the special cases; those results are
  // overridden below anyway.
  assign b_safe = (div_zero || div_ovf) ? 32'd1 : b;
  assign a_s    = a;
  assign b_s    = b_safe;
  assign quot_s = a_s / b_s;
  assign rem_s  = a_s % b_s;
  assign quot_u = a / b_safe;
  assign rem_u  = a % b_safe;

  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      MDU_MULT:  {hi_res, lo_res} = prod_s;
      MDU_MULTU: {hi_res, lo_res} = prod_u;
      MDU_DIV: begin
        if (div_zero) begin
          hi_res = a;
          lo_res = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          hi_res = 32'd0;
          lo_res = 32'h8000_0000;
        end else begin
          hi_res = rem_s;
          lo_res = quot_s;
        end
      end
      MDU_DIVU: begin
        if (div_zero) begin
          hi_res = a;
          lo_res = 32'hFFFF_FFFF;
        end else begin
          hi_res = rem_u;
          lo_res = quot_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, models operation latency with a busy
// counter, and drives the mf* result and the D-stage stall request.
module e_mdu
  import mdu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        E_Req,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_IsMDU,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_MDUOut,
  output logic        MDU_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     arith_hi, arith_lo;
  logic            is_div;

  mdu_arith u_arith (
    .op     (E_MDUOp),
    .a      (E_A),
    .b      (E_B),
    .hi_res (arith_hi),
    .lo_res (arith_lo)
  );

  assign E_Busy    = (state_q == StBusy);
  assign E_Start   = E_Req && is_start_op(E_MDUOp) && !E_Busy;
  assign MDU_Stall = D_IsMDU && (E_Start || E_Busy);
  assign is_div    = (E_MDUOp == MDU_DIV) || (E_MDUOp == MDU_DIVU);
  assign HI        = hi_q;
  assign LO        = lo_q;

  always_comb begin
    E_MDUOut = 32'd0;
    if (E_MDUOp == MDU_MFHI) E_MDUOut = hi_q;
    else if (E_MDUOp == MDU_MFLO) E_MDUOut = lo_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      StIdle: begin
        if (E_Start) begin
          state_d   = StBusy;
          cnt_d     = is_div ? DivLoad : MultLoad;
          pend_hi_d = arith_hi;
          pend_lo_d = arith_lo;
        end else if (E_Req && (E_MDUOp == MDU_MTHI)) begin
          hi_d = E_A;
        end else if (E_Req && (E_MDUOp == MDU_MTLO)) begin
          lo_d = E_A;
        end
      end
      StBusy: begin
        // Anything arriving while busy is ignored; the stall should keep it away.
        if (cnt_q == '0) begin
          state_d = StIdle;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: expected HI/LO pairs are queued at each start and
// compared when E_Busy drops.
module tb_e_mdu;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        E_Req;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_A, E_B;
  logic        D_IsMDU;
  logic        E_Start, E_Busy, MDU_Stall;
  logic [31:0] E_MDUOut, HI, LO;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic        busy_prev = 1'b0;

  always #5 clk = ~clk;

  e_mdu #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .E_Req     (E_Req),
    .E_MDUOp   (E_MDUOp),
    .E_A       (E_A),
    .E_B       (E_B),
    .D_IsMDU   (D_IsMDU),
    .E_Start   (E_Start),
    .E_Busy    (E_Busy),
    .E_MDUOut  (E_MDUOut),
    .MDU_Stall (MDU_Stall),
    .HI        (HI),
    .LO        (LO)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: each falling edge of E_Busy retires one queued result.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (busy_prev && !E_Busy) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_completion", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_hilo", {HI, LO}, e);
      end
    end
    busy_prev = E_Busy;
  end

  // Called at a negedge; returns at the first negedge with E_Busy low.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int n);
    int cyc;
    E_Req = 1'b1; E_MDUOp = op; E_A = a; E_B = b;
    #1;
    check({tag, "_start"}, E_Start, 1);
    exp_q.push_back(exp);
    @(negedge clk);
    E_Req = 1'b0; E_MDUOp = MDU_NONE;
    cyc = 0;
    while (E_Busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cyc, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset_n = 1'b0; E_Req = 1'b0; E_MDUOp = MDU_NONE; E_A = '0; E_B = '0; D_IsMDU = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", E_Busy, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_out", E_MDUOut, 0);
    check("rst_stall", MDU_Stall, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("mult", MDU_MULT, 32'd3, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 5);
    E_Req = 1'b1; E_MDUOp = MDU_MFLO;
    #1;
    check("mflo_after_mult", E_MDUOut, 32'hFFFF_FFFA);
    @(negedge clk);

    run_op("divu", MDU_DIVU, 32'd7, 32'd2, {32'd1, 32'd3}, 10);
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
    run_op("div_zero", MDU_DIV, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 10);
    run_op("divu_zero", MDU_DIVU, 32'h8000_0001, 32'd0, {32'h8000_0001, 32'hFFFF_FFFF}, 10);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5);

    // Start with an MDU op waiting in D; poke the unit with illegal ops while busy.
    D_IsMDU = 1'b1;
    E_Req = 1'b1; E_MDUOp = MDU_MULT; E_A = 32'd5; E_B = 32'd6;
    #1;
    check("stall_start_cycle", MDU_Stall, 1);
    check("stall_start", E_Start, 1);
    exp_q.push_back(64'd30);
    @(negedge clk);
    cyc = 0;
    while (E_Busy && cyc < 200) begin
      E_Req = 1'b0; E_MDUOp = MDU_NONE;
      if (cyc == 1) begin E_Req = 1'b1; E_MDUOp = MDU_MULT; E_A = 32'd7; E_B = 32'd7; end
      if (cyc == 2) begin E_Req = 1'b1; E_MDUOp = MDU_MFHI; end
      if (cyc == 3) begin E_Req = 1'b1; E_MDUOp = MDU_MTLO; E_A = 32'h55; end
      #1;
      check("stall_busy", MDU_Stall, 1);
      if (cyc == 1) check("start_while_busy", E_Start, 0);
      if (cyc == 2) check("mfhi_while_busy_old", E_MDUOut, 32'hFFFF_FFFE);
      cyc++;
      @(negedge clk);
    end
    E_Req = 1'b0; E_MDUOp = MDU_NONE;
    #1;
    check("stall_busy_cycles", cyc, 5);
    check("stall_released", MDU_Stall, 0);
    D_IsMDU = 1'b0;
    @(negedge clk);

    // MTHI then MFHI back-to-back.
    E_Req = 1'b1; E_MDUOp = MDU_MTHI; E_A = 32'hDEAD_BEEF;
    @(negedge clk);
    E_MDUOp = MDU_MFHI; E_A = 32'd0;
    #1;
    check("mfhi_after_mthi", E_MDUOut, 32'hDEAD_BEEF);
    check("lo_kept_after_mthi", LO, 32'd30);
    @(negedge clk);
    E_Req = 1'b0; E_MDUOp = MDU_MTLO; E_A = 32'h1111_1111;
    @(negedge clk);
    check("no_req_no_write", LO, 32'd30);

    // Reset on the 3rd busy cycle of a DIV discards the pending result.
    E_Req = 1'b1; E_MDUOp = MDU_DIV; E_A = 32'd100; E_B = 32'd7;
    #1;
    check("abort_start", E_Start, 1);
    exp_q.push_back(64'd0);
    @(negedge clk);
    E_Req = 1'b0; E_MDUOp = MDU_NONE;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_busy", E_Busy, 0);
    check("abort_hi", HI, 0);
    check("abort_lo", LO, 0);
    repeat (15) @(negedge clk);
    check("abort_no_late_update", {HI, LO}, 64'd0);
    check("abort_still_idle", E_Busy, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
